mem_arbiter: RTL

Round-robin arbiter placed directly upstream of the memory controller's consumer interface. It multiplexes NUM_CHANNELS independent read/write requesters (per-thread LSUs) onto the controller's single consumer read/write port. It carries one transaction at a time and routes the controller's response back to the granted channel.

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter multiplexing per-channel read/write requesters onto a
// single memory-controller port, one transaction in flight at a time.
module mem_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           ch_read_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_read_address,
    output logic [NUM_CHANNELS-1:0]           ch_read_ready,
    output logic [NUM_CHANNELS*DATA_BITS-1:0] ch_read_data,
    input  logic [NUM_CHANNELS-1:0]           ch_write_valid,
    input  logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_write_address,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0] ch_write_data,
    output logic [NUM_CHANNELS-1:0]           ch_write_ready,
    output logic                              ctrl_read_valid,
    output logic [ADDR_BITS-1:0]              ctrl_read_address,
    input  logic                              ctrl_read_ready,
    input  logic [DATA_BITS-1:0]              ctrl_read_data,
    output logic                              ctrl_write_valid,
    output logic [ADDR_BITS-1:0]              ctrl_write_address,
    output logic [DATA_BITS-1:0]              ctrl_write_data,
    input  logic                              ctrl_write_ready,
    output logic                              busy,
    output logic [$clog2(NUM_CHANNELS)-1:0]   grant_channel
);

    localparam int CW = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        WRITE_WAIT,
        RELEASE
    } state_t;

    state_t        state;
    logic [CW-1:0] rr_ptr;
    logic          found;
    logic [CW-1:0] winner;
    logic [CW:0]   scan;
    logic [CW-1:0] idx;
    logic [CW-1:0] next_ptr;

    // First requesting channel starting at rr_ptr, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        scan   = '0;
        idx    = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            scan = {1'b0, rr_ptr} + (CW+1)'(k);
            if (scan >= (CW+1)'(NUM_CHANNELS))
                scan = scan - (CW+1)'(NUM_CHANNELS);
            idx = scan[CW-1:0];
            if (!found && (ch_read_valid[idx] || ch_write_valid[idx])) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign next_ptr = (grant_channel == CW'(NUM_CHANNELS-1)) ?
                      '0 : grant_channel + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            grant_channel      <= '0;
            busy               <= 1'b0;
            ctrl_read_valid    <= 1'b0;
            ctrl_read_address  <= '0;
            ctrl_write_valid   <= 1'b0;
            ctrl_write_address <= '0;
            ctrl_write_data    <= '0;
            ch_read_ready      <= '0;
            ch_write_ready     <= '0;
            ch_read_data       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_channel <= winner;
                        busy          <= 1'b1;
                        // A channel with both requests gets its read first.
                        if (ch_read_valid[winner]) begin
                            ctrl_read_valid   <= 1'b1;
                            ctrl_read_address <=
                                ch_read_address[winner*ADDR_BITS +: ADDR_BITS];
                            state             <= READ_WAIT;
                        end else begin
                            ctrl_write_valid   <= 1'b1;
                            ctrl_write_address <=
                                ch_write_address[winner*ADDR_BITS +: ADDR_BITS];
                            ctrl_write_data    <=
                                ch_write_data[winner*DATA_BITS +: DATA_BITS];
                            state              <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (ctrl_read_ready) begin
                        ctrl_read_valid <= 1'b0;
                        ch_read_data[grant_channel*DATA_BITS +: DATA_BITS]
                            <= ctrl_read_data;
                        ch_read_ready[grant_channel] <= 1'b1;
                        rr_ptr <= next_ptr;
                        state  <= RELEASE;
                    end
                end
                WRITE_WAIT: begin
                    if (ctrl_write_ready) begin
                        ctrl_write_valid <= 1'b0;
                        ch_write_ready[grant_channel] <= 1'b1;
                        rr_ptr <= next_ptr;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    ch_read_ready  <= '0;
                    ch_write_ready <= '0;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
